// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - state, opcode/funct and select encodings for the multi-cycle MIPS control path
package mips_ctrl_pkg;

  typedef enum logic [2:0] {
    st_if,
    st_id,
    st_exe,
    st_mem,
    st_wb,
    st_halt
  } state_t;

  localparam logic [5:0] op_rtype = 6'b000000;
  localparam logic [5:0] op_addi  = 6'b001000;
  localparam logic [5:0] op_ori   = 6'b001101;
  localparam logic [5:0] op_lw    = 6'b100011;
  localparam logic [5:0] op_sw    = 6'b101011;
  localparam logic [5:0] op_beq   = 6'b000100;
  localparam logic [5:0] op_bne   = 6'b000101;
  localparam logic [5:0] op_j     = 6'b000010;
  localparam logic [5:0] op_halt  = 6'b111111;

  localparam logic [5:0] fn_add = 6'b100000;
  localparam logic [5:0] fn_sub = 6'b100010;
  localparam logic [5:0] fn_and = 6'b100100;
  localparam logic [5:0] fn_or  = 6'b100101;
  localparam logic [5:0] fn_slt = 6'b101010;
  localparam logic [5:0] fn_sll = 6'b000000;

  typedef enum logic [2:0] {
    alu_add = 3'b000,
    alu_sub = 3'b001,
    alu_and = 3'b010,
    alu_or  = 3'b011,
    alu_slt = 3'b100,
    alu_sll = 3'b101
  } alu_op_t;

  typedef enum logic [1:0] {
    pc_plus4  = 2'b00,
    pc_branch = 2'b01,
    pc_jump   = 2'b10
  } pc_src_t;

endpackage

// File: rtl/alu_ctrl.sv
// rtl/alu_ctrl.sv - combinational opcode/funct decode into ALU controls and legality
module alu_ctrl
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [2:0] alu_op,
  output logic       alu_src_b,
  output logic       ext_zero,
  output logic       legal
);

  always_comb begin
    alu_op    = alu_add;
    alu_src_b = 1'b0;
    ext_zero  = 1'b0;
    legal     = 1'b1;
    case (opcode)
      op_rtype: begin
        case (funct)
          fn_add:  alu_op = alu_add;
          fn_sub:  alu_op = alu_sub;
          fn_and:  alu_op = alu_and;
          fn_or:   alu_op = alu_or;
          fn_slt:  alu_op = alu_slt;
          fn_sll:  alu_op = alu_sll;
          default: legal = 1'b0;
        endcase
      end
      op_addi, op_lw, op_sw: alu_src_b = 1'b1;
      op_ori: begin
        alu_op    = alu_or;
        alu_src_b = 1'b1;
        ext_zero  = 1'b1;
      end
      // Branches compare by subtraction; the zero flag decides the outcome.
      op_beq, op_bne: alu_op = alu_sub;
      op_j, op_halt: ;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// rtl/multi_cycle_ctrl.sv - multi-cycle MIPS control FSM; MULTI_CYCLE_CTRL_PERF_EN adds cycle/instruction counters
module multi_cycle_ctrl
  import mips_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        imem_ack,
  input  logic        dmem_ack,
  output logic        imem_req,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        alu_src_b,
  output logic        ext_zero,
  output logic [2:0]  alu_op,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        wb_src,
  output logic        illegal,
  output logic        halted
`ifdef MULTI_CYCLE_CTRL_PERF_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instr_cnt
`endif
);

  state_t     state;
  logic [2:0] dec_alu_op;
  logic       dec_src_b;
  logic       dec_ext_zero;
  logic       dec_legal;
  logic       is_rtype;
  logic       is_lw;
  logic       is_sw;
  logic       is_mem;
  logic       is_branch;
  logic       br_taken;

  alu_ctrl u_alu_ctrl (
    .opcode    (opcode),
    .funct     (funct),
    .alu_op    (dec_alu_op),
    .alu_src_b (dec_src_b),
    .ext_zero  (dec_ext_zero),
    .legal     (dec_legal)
  );

  assign is_rtype  = (opcode == op_rtype);
  assign is_lw     = (opcode == op_lw);
  assign is_sw     = (opcode == op_sw);
  assign is_mem    = is_lw | is_sw;
  assign is_branch = (opcode == op_beq) | (opcode == op_bne);
  assign br_taken  = (opcode == op_beq) ? zero : !zero;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= st_if;
    end else begin
      case (state)
        st_if:   if (imem_ack) state <= st_id;
        st_id: begin
          if (!dec_legal || opcode == op_j) state <= st_if;
          else if (opcode == op_halt)       state <= st_halt;
          else                              state <= st_exe;
        end
        st_exe: begin
          if (is_branch)   state <= st_if;
          else if (is_mem) state <= st_mem;
          else             state <= st_wb;
        end
        st_mem:  if (dmem_ack) state <= is_lw ? st_wb : st_if;
        st_wb:   state <= st_if;
        st_halt: state <= st_halt;
        default: state <= st_if;
      endcase
    end
  end

  // Outputs decode from state plus live ack/zero so a same-cycle ack or branch
  // outcome acts immediately; rst gates everything off without waiting for a clock.
  always_comb begin
    imem_req  = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = pc_plus4;
    alu_src_b = 1'b0;
    ext_zero  = 1'b0;
    alu_op    = alu_add;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    reg_write = 1'b0;
    reg_dst   = 1'b0;
    wb_src    = 1'b0;
    illegal   = 1'b0;
    halted    = 1'b0;
    if (!rst) begin
      case (state)
        st_if: begin
          imem_req = 1'b1;
          if (imem_ack) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            pc_src   = pc_plus4;
          end
        end
        st_id: begin
          illegal = !dec_legal;
          if (dec_legal && opcode == op_j) begin
            pc_write = 1'b1;
            pc_src   = pc_jump;
          end
        end
        st_exe: begin
          alu_op    = dec_alu_op;
          alu_src_b = dec_src_b;
          ext_zero  = dec_ext_zero;
          if (is_branch && br_taken) begin
            pc_write = 1'b1;
            pc_src   = pc_branch;
          end
        end
        st_mem: begin
          dmem_req = 1'b1;
          dmem_we  = is_sw;
          alu_op   = alu_add;
        end
        st_wb: begin
          reg_write = 1'b1;
          reg_dst   = is_rtype;
          wb_src    = is_lw;
          alu_op    = dec_alu_op;
          alu_src_b = dec_src_b;
        end
        st_halt: halted = 1'b1;
        default: ;
      endcase
    end
  end

`ifdef MULTI_CYCLE_CTRL_PERF_EN
  logic retire;

  // An instruction retires on its last cycle before IF; illegal ones never retire.
  assign retire = (state == st_id && dec_legal && opcode == op_j) ||
                  (state == st_exe && is_branch) ||
                  (state == st_mem && is_sw && dmem_ack) ||
                  (state == st_wb);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      if (state != st_halt) cycle_cnt <= cycle_cnt + 32'd1;
      if (retire)           instr_cnt <= instr_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// tb/tb_multi_cycle_ctrl.sv - randomized self-checking bench; expected traces built per instruction from the phase rules
module tb_multi_cycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode, funct;
  logic       zero, imem_ack, dmem_ack;
  logic       imem_req, ir_write, pc_write;
  logic [1:0] pc_src;
  logic       alu_src_b, ext_zero;
  logic [2:0] alu_op;
  logic       dmem_req, dmem_we, reg_write, reg_dst, wb_src, illegal, halted;
`ifdef MULTI_CYCLE_CTRL_PERF_EN
  logic [31:0] cycle_cnt, instr_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  multi_cycle_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .opcode    (opcode),
    .funct     (funct),
    .zero      (zero),
    .imem_ack  (imem_ack),
    .dmem_ack  (dmem_ack),
    .imem_req  (imem_req),
    .ir_write  (ir_write),
    .pc_write  (pc_write),
    .pc_src    (pc_src),
    .alu_src_b (alu_src_b),
    .ext_zero  (ext_zero),
    .alu_op    (alu_op),
    .dmem_req  (dmem_req),
    .dmem_we   (dmem_we),
    .reg_write (reg_write),
    .reg_dst   (reg_dst),
    .wb_src    (wb_src),
    .illegal   (illegal),
    .halted    (halted)
`ifdef MULTI_CYCLE_CTRL_PERF_EN
    ,
    .cycle_cnt (cycle_cnt),
    .instr_cnt (instr_cnt)
`endif
  );

  typedef struct packed {
    logic       imem_req, ir_write, pc_write;
    logic [1:0] pc_src;
    logic       alu_src_b, ext_zero;
    logic [2:0] alu_op;
    logic       dmem_req, dmem_we, reg_write, reg_dst, wb_src, illegal, halted;
  } outs_t;

  typedef struct {
    logic [5:0] op, fn;
    logic       ia, da, z;
    outs_t      exp;
  } step_t;

  outs_t obs;
  step_t plan[$];

  assign obs = {imem_req, ir_write, pc_write, pc_src, alu_src_b, ext_zero, alu_op,
                dmem_req, dmem_we, reg_write, reg_dst, wb_src, illegal, halted};

  function automatic bit supported(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'b000000: return fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
      6'b001000, 6'b001101, 6'b100011, 6'b101011,
      6'b000100, 6'b000101, 6'b000010, 6'b111111: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] ref_alu(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'b000000) begin
      case (fn)
        6'b100010: return 3'd1;
        6'b100100: return 3'd2;
        6'b100101: return 3'd3;
        6'b101010: return 3'd4;
        6'b000000: return 3'd5;
        default:   return 3'd0;
      endcase
    end
    if (op == 6'b001101) return 3'd3;
    if (op == 6'b000100 || op == 6'b000101) return 3'd1;
    return 3'd0;
  endfunction

  function automatic step_t fresh(input logic [5:0] op, input logic [5:0] fn);
    step_t s;
    s.op  = op;
    s.fn  = fn;
    s.ia  = 1'($urandom_range(0, 1));
    s.da  = 1'($urandom_range(0, 1));
    s.z   = 1'($urandom_range(0, 1));
    s.exp = '0;
    return s;
  endfunction

  // Append the expected cycle-by-cycle trace of one instruction to the plan.
  task automatic push_instr(input logic [5:0] op, input logic [5:0] fn, input int iw,
                            input int dw, input logic z, input int halt_cycles);
    step_t s;
    bit    imm, mem;
    imm = op inside {6'b001000, 6'b001101, 6'b100011, 6'b101011};
    mem = op inside {6'b100011, 6'b101011};
    for (int i = 0; i <= iw; i++) begin
      s = fresh(op, fn);
      s.ia = (i == iw);
      s.exp.imem_req = 1'b1;
      if (i == iw) begin
        s.exp.ir_write = 1'b1;
        s.exp.pc_write = 1'b1;
      end
      plan.push_back(s);
    end
    s = fresh(op, fn);
    if (!supported(op, fn)) s.exp.illegal = 1'b1;
    else if (op == 6'b000010) begin
      s.exp.pc_write = 1'b1;
      s.exp.pc_src   = 2'b10;
    end
    plan.push_back(s);
    if (!supported(op, fn) || op == 6'b000010) return;
    if (op == 6'b111111) begin
      for (int i = 0; i < halt_cycles; i++) begin
        s = fresh(op, fn);
        s.exp.halted = 1'b1;
        plan.push_back(s);
      end
      return;
    end
    s = fresh(op, fn);
    s.z = z;
    s.exp.alu_op    = ref_alu(op, fn);
    s.exp.alu_src_b = imm;
    s.exp.ext_zero  = (op == 6'b001101);
    if (op == 6'b000100 || op == 6'b000101) begin
      if ((op == 6'b000100) ? z : !z) begin
        s.exp.pc_write = 1'b1;
        s.exp.pc_src   = 2'b01;
      end
      plan.push_back(s);
      return;
    end
    plan.push_back(s);
    if (mem) begin
      for (int i = 0; i <= dw; i++) begin
        s = fresh(op, fn);
        s.da = (i == dw);
        s.exp.dmem_req = 1'b1;
        s.exp.dmem_we  = (op == 6'b101011);
        plan.push_back(s);
      end
      if (op == 6'b101011) return;
    end
    s = fresh(op, fn);
    s.exp.reg_write = 1'b1;
    s.exp.reg_dst   = (op == 6'b000000);
    s.exp.wb_src    = (op == 6'b100011);
    s.exp.alu_op    = ref_alu(op, fn);
    s.exp.alu_src_b = imm;
    plan.push_back(s);
  endtask

  // Entered just after a rising edge; leaves just after the edge ending the last step.
  task automatic run_plan(input string nm);
    step_t s;
    int    cyc = 0;
    while (plan.size() > 0) begin
      s = plan.pop_front();
      opcode   = s.op;
      funct    = s.fn;
      imem_ack = s.ia;
      dmem_ack = s.da;
      zero     = s.z;
      @(negedge clk);
      vectors++;
      if (obs !== s.exp) begin
        miscompares++;
        $display("FAIL %s cycle %0d: outputs %h, required %h", nm, cyc, obs, s.exp);
      end
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic apply_reset(input string nm);
    outs_t e;
    #1 rst = 1'b1;
    imem_ack = 1'b1;
    dmem_ack = 1'b1;
    zero     = 1'b1;
    #1;
    vectors++;
    if (obs !== '0) begin
      miscompares++;
      $display("FAIL %s_assert: outputs %h, required 0", nm, obs);
    end
    repeat (2) begin
      @(negedge clk);
      vectors++;
      if (obs !== '0) begin
        miscompares++;
        $display("FAIL %s_hold: outputs %h, required 0", nm, obs);
      end
    end
    @(posedge clk);
    #1;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    rst      = 1'b0;
    #1;
    e = '0;
    e.imem_req = 1'b1;
    vectors++;
    if (obs !== e) begin
      miscompares++;
      $display("FAIL %s_release: outputs %h, required %h", nm, obs, e);
    end
  endtask

  task automatic test_addi();
    push_instr(6'b001000, 6'b000000, 0, 0, 1'b0, 0);
    push_instr(6'b000000, 6'b100000, 1, 0, 1'b0, 0);
    push_instr(6'b001101, 6'b000000, 0, 0, 1'b0, 0);
    run_plan("addi");
  endtask

  task automatic test_lw_wait();
    push_instr(6'b100011, 6'b000000, 0, 2, 1'b0, 0);
    push_instr(6'b101011, 6'b000000, 2, 0, 1'b0, 0);
    run_plan("lw_wait");
  endtask

  task automatic test_branch();
    push_instr(6'b000100, 6'b000000, 0, 0, 1'b1, 0);
    push_instr(6'b000100, 6'b000000, 0, 0, 1'b0, 0);
    push_instr(6'b000101, 6'b000000, 0, 0, 1'b1, 0);
    push_instr(6'b000101, 6'b000000, 0, 0, 1'b0, 0);
    run_plan("branch");
  endtask

  task automatic test_jump();
    push_instr(6'b000010, 6'b000000, 0, 0, 1'b0, 0);
    push_instr(6'b000000, 6'b000000, 0, 0, 1'b0, 0);
    run_plan("jump");
  endtask

  task automatic test_reset_mid_mem();
    outs_t e;
    push_instr(6'b101011, 6'b000000, 0, 5, 1'b0, 0);
    while (plan.size() > 4) void'(plan.pop_back());
    run_plan("sw_pre_rst");
    dmem_ack = 1'b0;
    #1;
    e = '0;
    e.dmem_req = 1'b1;
    e.dmem_we  = 1'b1;
    vectors++;
    if (obs !== e) begin
      miscompares++;
      $display("FAIL mid_mem_wait: outputs %h, required %h", obs, e);
    end
    apply_reset("mid_mem");
  endtask

  task automatic test_random();
    logic [5:0] op, fn;
    for (int n = 0; n < 80; n++) begin
      fn = 6'b000000;
      case ($urandom_range(0, 10))
        0: begin
          op = 6'b000000;
          case ($urandom_range(0, 5))
            0: fn = 6'b100000;
            1: fn = 6'b100010;
            2: fn = 6'b100100;
            3: fn = 6'b100101;
            4: fn = 6'b101010;
            default: fn = 6'b000000;
          endcase
        end
        1: op = 6'b001000;
        2: op = 6'b001101;
        3: op = 6'b100011;
        4: op = 6'b101011;
        5: op = 6'b000100;
        6: op = 6'b000101;
        7: op = 6'b000010;
        8: begin
          op = 6'b000000;
          do fn = 6'($urandom_range(0, 63)); while (supported(op, fn));
        end
        9: begin
          do op = 6'($urandom_range(0, 63)); while (supported(op, 6'b000000));
        end
        default: op = 6'b000000;
      endcase
      push_instr(op, fn, $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom_range(0, 1)), 0);
    end
    run_plan("random");
  endtask

  task automatic test_illegal_halt();
    push_instr(6'b010001, 6'b000000, 0, 0, 1'b0, 0);
    push_instr(6'b111111, 6'b000000, 1, 0, 1'b0, 20);
    run_plan("illegal_halt");
    apply_reset("halt_exit");
    push_instr(6'b001000, 6'b000000, 0, 0, 1'b0, 0);
    run_plan("after_halt");
  endtask

`ifdef MULTI_CYCLE_CTRL_PERF_EN
  task automatic test_perf();
    logic [31:0] c0, i0;
    apply_reset("perf_rst");
    vectors++;
    if (cycle_cnt !== 32'd0 || instr_cnt !== 32'd0) begin
      miscompares++;
      $display("FAIL perf_reset: cycle %0d instr %0d, required 0 0", cycle_cnt, instr_cnt);
    end
    push_instr(6'b001000, 6'b000000, 0, 0, 1'b0, 0);
    push_instr(6'b000100, 6'b000000, 0, 0, 1'($urandom_range(0, 1)), 0);
    push_instr(6'b100011, 6'b000000, 0, 0, 1'b0, 0);
    run_plan("perf_run");
    vectors++;
    if (cycle_cnt !== 32'd12 || instr_cnt !== 32'd3) begin
      miscompares++;
      $display("FAIL perf_counts: cycle %0d instr %0d, required 12 3", cycle_cnt, instr_cnt);
    end
    c0 = cycle_cnt;
    i0 = instr_cnt;
    push_instr(6'b010001, 6'b000000, 0, 0, 1'b0, 0);
    push_instr(6'b001000, 6'b000000, 0, 0, 1'b0, 0);
    run_plan("perf_illegal");
    vectors++;
    if (cycle_cnt !== c0 + 32'd6 || instr_cnt !== i0 + 32'd1) begin
      miscompares++;
      $display("FAIL perf_illegal_cnt: cycle %0d instr %0d, required %0d %0d",
               cycle_cnt, instr_cnt, c0 + 32'd6, i0 + 32'd1);
    end
  endtask
`endif

  initial begin
    rst      = 1'b1;
    opcode   = 6'b000000;
    funct    = 6'b000000;
    zero     = 1'b0;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    repeat (2) @(posedge clk);
    apply_reset("reset");
    test_addi();
    test_lw_wait();
    test_branch();
    test_jump();
    test_reset_mid_mem();
    test_random();
`ifdef MULTI_CYCLE_CTRL_PERF_EN
    test_perf();
`endif
    test_illegal_halt();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multi_cycle_ctrl.md
# multi_cycle_ctrl

Multi-cycle control FSM for the MIPS core. It sequences instruction fetch, decode, execute, memory and write-back around the field decoder's `opcode`/`funct` outputs. It handshakes with instruction and data memory and drives every datapath enable and mux select: PC, IR, register file, ALU and memory. One instruction is in flight at a time.

## Interface
- Parameters: none.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `opcode` in 6: from the decoder, taken from the IR; stable from ID onward.
- `funct` in 6: from the decoder.
- `zero` in 1: ALU zero flag, valid in EXE.
- `imem_ack` in 1: instruction word valid; may assert in the same cycle as `imem_req`.
- `dmem_ack` in 1: data access complete; may assert in the same cycle as `dmem_req`.
- `imem_req` out 1: fetch request.
- `ir_write` out 1: load IR.
- `pc_write` out 1: update PC.
- `pc_src` out 2: 00 = PC+4, 01 = branch target, 10 = jump target.
- `alu_src_b` out 1: 0 = rt, 1 = extended immediate.
- `ext_zero` out 1: 1 = zero-extend immediate (ori), 0 = sign-extend.
- `alu_op` out 3: 000 add, 001 sub, 010 and, 011 or, 100 slt, 101 sll.
- `dmem_req` out 1: data memory request.
- `dmem_we` out 1: data memory write enable.
- `reg_write` out 1: register file write enable.
- `reg_dst` out 1: 1 = rd, 0 = rt.
- `wb_src` out 1: 1 = memory data, 0 = ALU result.
- `illegal` out 1: one-cycle pulse on an unsupported opcode or funct.
- `halted` out 1: core stopped.

## Operation
- Supported instructions:
  - R-type (000000) with funct add 100000, sub 100010, and 100100, or 100101, slt 101010, sll 000000.
  - addi 001000, ori 001101, lw 100011, sw 101011, beq 000100, bne 000101, j 000010, halt 111111.
- State transitions:
  - IF → ID when `imem_ack`.
  - ID → IF for j; → HALT for halt; → IF with `illegal` for unknown opcode or funct; → EXE otherwise.
  - EXE → IF for beq/bne; → MEM for lw/sw; → WB otherwise.
  - MEM → WB for lw when `dmem_ack`; → IF for sw when `dmem_ack`.
  - WB → IF.
  - HALT is sticky until `rst`.
- Outputs per state (all outputs 0 outside these cases):
  - IF: `imem_req`=1. When `imem_ack`: `ir_write`=1, `pc_write`=1, `pc_src`=00.
  - ID, j: `pc_write`=1, `pc_src`=10.
  - EXE: `alu_op` per instruction; `alu_src_b`=1 for addi/ori/lw/sw; `ext_zero`=1 for ori only.
  - EXE, beq/bne: `alu_op`=sub; `pc_write`=1 with `pc_src`=01 when `zero` (beq) or `!zero` (bne).
  - MEM: `dmem_req`=1 and `alu_op`=add held; `dmem_we`=1 for sw.
  - WB: `reg_write`=1; `reg_dst`=1 for R-type; `wb_src`=1 for lw; `alu_op`/`alu_src_b` held from EXE.
- PC+4 is written in IF, so branch and jump targets are computed from the incremented PC.
- An sll with rd=0, i.e. the all-zero instruction word (nop), executes as a normal R-type.

## Timing
- Reset:
  - State goes to IF asynchronously.
  - All outputs are 0 during reset.
  - `imem_req` rises in the first cycle after `rst` deasserts.
- Latency with zero-wait memory:
  - j: 2 cycles.
  - beq/bne: 3 cycles.
  - R-type/addi/ori/sw: 4 cycles.
  - lw: 5 cycles.
- Each cycle of `imem_ack`/`dmem_ack` absence adds exactly one cycle. The request stays high and all other outputs stay stable while waiting.
- `ack` outside IF/MEM is ignored.
- `rst` asserted mid-instruction (e.g. in MEM) drops the pending request immediately. No partial `reg_write` or `pc_write` is issued.
- `illegal` is a 1-cycle pulse, in the ID cycle.
- `halted` is 1 in every HALT cycle.

## Configuration
- `MULTI_CYCLE_CTRL_PERF_EN` defined:
  - Adds output ports `cycle_cnt` [31:0] and `instr_cnt` [31:0]. Both reset to 0.
  - `cycle_cnt` increments every non-HALT cycle.
  - `instr_cnt` increments on each transition back into IF from ID, EXE, MEM or WB. Illegal instructions do not count.
  - Both counters wrap modulo 2^32.
- Macro undefined: the ports and counters are absent; the rest of the behaviour is identical.

## Structure
- Package `mips_ctrl_pkg` holds:
  - the state enum (IF, ID, EXE, MEM, WB, HALT);
  - opcode and funct localparams;
  - `alu_op` and `pc_src` encodings.
- Sub-module `alu_ctrl` (combinational) maps opcode/funct to `alu_op`, `alu_src_b`, `ext_zero` and legality.
- The FSM stays in `multi_cycle_ctrl`.

## Test plan
- addi ($t0 = $0 + 5), acks tied high → states IF, ID, EXE, WB. `alu_src_b`=1 and `alu_op`=000 in EXE; `reg_write`=1 with `reg_dst`=0 in cycle 4; next IF in cycle 5.
- lw with `dmem_ack` delayed 2 cycles → `dmem_req` high for 3 cycles, then WB with `wb_src`=1; total 7 cycles.
- beq with `zero`=1 → `pc_write`=1 and `pc_src`=01 in EXE. Same with `zero`=0 → no `pc_write`. bne mirrors both.
- j → `pc_write`=1 and `pc_src`=10 in ID; IF again in cycle 3.
- opcode 010001, then halt → `illegal` pulses once and no `reg_write` follows. halt → `halted`=1 stays high for 20 cycles; `rst` returns to IF.
- `rst` asserted mid-MEM on sw → `dmem_req` drops without waiting for a clock edge. With PERF_EN: 3 retired instructions over 12 cycles → `instr_cnt`=3, `cycle_cnt`=12.
